// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter/rotator, one stage per sel bit, valid/ready flow.
// Define SHIFTER_STATUS_EN to add the pipelined zero/carry status outputs.
module pipelined_barrel_shifter #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   sel,
   input  logic [2:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] b
`ifdef SHIFTER_STATUS_EN
   ,
   output logic             zero,
   output logic             carry
`endif
);

   localparam logic [2:0] M_SLL = 3'b000;
   localparam logic [2:0] M_SRL = 3'b001;
   localparam logic [2:0] M_SRA = 3'b010;
   localparam logic [2:0] M_ROL = 3'b011;
   localparam logic [2:0] M_ROR = 3'b100;

   function automatic logic [WIDTH-1:0] step(
      input logic [WIDTH-1:0] d,
      input logic [2:0]       m,
      input int               s
   );
      case (m)
         M_SLL:   return d << s;
         M_SRL:   return d >> s;
         M_SRA:   return $signed(d) >>> s;
         M_ROL:   return (d << s) | (d >> (WIDTH - s));
         M_ROR:   return (d >> s) | (d << (WIDTH - s));
         default: return d;
      endcase
   endfunction

`ifdef SHIFTER_STATUS_EN
   // Last bit leaving this stage; earlier stages already moved the data.
   function automatic logic cout(
      input logic [WIDTH-1:0] d,
      input logic [2:0]       m,
      input int               s
   );
      logic [SHW-1:0] lo;
      logic [SHW-1:0] hi;
      lo = SHW'(s - 1);
      hi = SHW'(WIDTH - s);
      case (m)
         M_SLL, M_ROL:        return d[hi];
         M_SRL, M_SRA, M_ROR: return d[lo];
         default:             return 1'b0;
      endcase
   endfunction
`endif

   logic             advance;

   logic             v_q [SHW];
   logic [WIDTH-1:0] d_q [SHW];
   logic [SHW-1:0]   s_q [SHW-1];
   logic [2:0]       m_q [SHW-1];

   logic             vi  [SHW];
   logic [WIDTH-1:0] di  [SHW];
   logic [SHW-1:0]   si  [SHW];
   logic [2:0]       mi  [SHW];
   logic [WIDTH-1:0] d_d [SHW];

`ifdef SHIFTER_STATUS_EN
   logic             c_q [SHW];
   logic             ci  [SHW];
   logic             c_d [SHW];
   logic             z_q;
`endif

   assign advance   = ~v_q[SHW-1] | out_ready;
   assign in_ready  = advance;
   assign out_valid = v_q[SHW-1];
   assign b         = d_q[SHW-1];

`ifdef SHIFTER_STATUS_EN
   assign zero  = z_q;
   assign carry = c_q[SHW-1];
`endif

   // Remaining sel bits travel right-aligned: bit 0 belongs to the stage.
   always_comb begin
      vi[0] = in_valid & advance;
      di[0] = a;
      si[0] = sel;
      mi[0] = mode;
      for (int k = 1; k < SHW; k++) begin
         vi[k] = v_q[k-1];
         di[k] = d_q[k-1];
         si[k] = s_q[k-1];
         mi[k] = m_q[k-1];
      end
      for (int k = 0; k < SHW; k++) begin
         d_d[k] = si[k][0] ? step(di[k], mi[k], 1 << k) : di[k];
      end
   end

`ifdef SHIFTER_STATUS_EN
   always_comb begin
      ci[0] = 1'b0;
      for (int k = 1; k < SHW; k++) begin
         ci[k] = c_q[k-1];
      end
      for (int k = 0; k < SHW; k++) begin
         c_d[k] = si[k][0] ? cout(di[k], mi[k], 1 << k) : ci[k];
      end
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < SHW; k++) begin
            v_q[k] <= 1'b0;
            d_q[k] <= '0;
         end
         for (int k = 0; k < SHW - 1; k++) begin
            s_q[k] <= '0;
            m_q[k] <= '0;
         end
      end else if (advance) begin
         for (int k = 0; k < SHW; k++) begin
            v_q[k] <= vi[k];
            if (vi[k]) d_q[k] <= d_d[k];
         end
         for (int k = 0; k < SHW - 1; k++) begin
            if (vi[k]) begin
               s_q[k] <= si[k] >> 1;
               m_q[k] <= mi[k];
            end
         end
      end
   end

`ifdef SHIFTER_STATUS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < SHW; k++) c_q[k] <= 1'b0;
         z_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < SHW; k++) begin
            if (vi[k]) c_q[k] <= c_d[k];
         end
         if (vi[SHW-1]) z_q <= (d_d[SHW-1] == '0);
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Testbench for pipelined_barrel_shifter: vector table, corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_pipelined_barrel_shifter;

   localparam int W  = 32;
   localparam int SW = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [SW-1:0] sel;
   logic [2:0]    mode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  b;
`ifdef SHIFTER_STATUS_EN
   logic          zero;
   logic          carry;
`endif

   pipelined_barrel_shifter #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .sel       (sel),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .b         (b)
`ifdef SHIFTER_STATUS_EN
      ,
      .zero      (zero),
      .carry     (carry)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] b;
      logic         c;
      logic         z;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      int           s;
      int           m;
      logic [W-1:0] b;
      logic         c;
   } vec_t;

   res_t         sb[$];
   int           compared   = 0;
   int           mismatched = 0;
   logic         ov_s, acc_s, c_s, z_s;
   logic [W-1:0] b_s;
   logic         hold_prev = 1'b0;
   logic [W-1:0] prev_b;

   task automatic check(input string name, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Whole-word reference computed directly from the operation definition.
   function automatic res_t model(input logic [W-1:0] x, input int s,
                                  input int m);
      res_t r;
      case (m)
         0:       r.b = x << s;
         1:       r.b = x >> s;
         2:       r.b = $signed(x) >>> s;
         3:       r.b = (s == 0) ? x : ((x << s) | (x >> (W - s)));
         4:       r.b = (s == 0) ? x : ((x >> s) | (x << (W - s)));
         default: r.b = x;
      endcase
      r.c = 1'b0;
      if (s != 0 && m <= 4) begin
         if (m == 0 || m == 3) r.c = 1'(x >> (W - s));
         else                  r.c = 1'(x >> (s - 1));
      end
      r.z = (r.b == '0);
      return r;
   endfunction

   task automatic tick();
      res_t e;
      @(negedge clock);
      ov_s = out_valid;
      b_s  = b;
`ifdef SHIFTER_STATUS_EN
      c_s = carry;
      z_s = zero;
`else
      c_s = 1'b0;
      z_s = 1'b0;
`endif
      check("in_ready", W'(in_ready), W'(!out_valid || out_ready));
      if (hold_prev) begin
         check("hold_valid", W'(out_valid), W'(1));
         check("hold_b", b, prev_b);
      end
      if (out_valid && sb.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL stale: got out_valid=1 b=0x%0h, expected nothing",
                  b);
      end else if (out_valid && out_ready) begin
         e = sb.pop_front();
         check("b", b, e.b);
`ifdef SHIFTER_STATUS_EN
         check("carry", W'(carry), W'(e.c));
         check("zero", W'(zero), W'(e.z));
`endif
      end
      acc_s = in_valid && in_ready;
      if (acc_s) sb.push_back(model(a, int'(sel), int'(mode)));
      hold_prev = out_valid && !out_ready;
      prev_b    = b;
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         tick();
         n++;
      end
      check("drain_empty", W'(sb.size()), W'(0));
      repeat (4) tick();
   endtask

   task automatic one_op(input logic [W-1:0] x, input int s, input int m,
                         output int lat);
      a        = x;
      sel      = SW'(s);
      mode     = 3'(m);
      in_valid = 1'b1;
      tick();
      check("accepted", W'(acc_s), W'(1));
      in_valid = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!ov_s && lat < 20);
      if (!ov_s) begin
         compared++;
         mismatched++;
         $display("FAIL timeout: got no out_valid, expected one");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tv[17];
      logic [W-1:0] vals[6];
      logic [W-1:0] exp6[6];
      logic [W-1:0] got[$];
      int           lat, first_v, last_v, nv;

      tv[0]  = '{32'h0000001F, 5, 3, 32'h000003E0, 1'b0};
      tv[1]  = '{32'h0000001F, 5, 4, 32'hF8000000, 1'b1};
      tv[2]  = '{32'h80000000, 31, 2, 32'hFFFFFFFF, 1'b0};
      tv[3]  = '{32'h80000000, 31, 1, 32'h00000001, 1'b0};
      tv[4]  = '{32'hFFFFFFFF, 4, 0, 32'hFFFFFFF0, 1'b1};
      tv[5]  = '{32'h80000001, 1, 0, 32'h00000002, 1'b1};
      tv[6]  = '{32'h80000000, 1, 3, 32'h00000001, 1'b1};
      tv[7]  = '{32'hF0000000, 4, 2, 32'hFF000000, 1'b0};
      tv[8]  = '{32'h12345678, 7, 7, 32'h12345678, 1'b0};
      for (int m = 0; m < 8; m++)
         tv[9+m] = '{32'hDEADBEEF, 0, m, 32'hDEADBEEF, 1'b0};

      vals = '{32'h1F, 32'h3F, 32'h7F, 32'hFF, 32'h1FF, 32'h3FF};
      exp6 = '{32'h3E0, 32'h7E0, 32'hFE0, 32'h1FE0, 32'h3FE0, 32'h7FE0};

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      sel       = '0;
      mode      = '0;
      #1;
      check("rst_valid", W'(out_valid), W'(0));
      check("rst_b", b, '0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check("rst_in_ready", W'(in_ready), W'(1));

      for (int i = 0; i < 17; i++) begin
         one_op(tv[i].a, tv[i].s, tv[i].m, lat);
         check("tbl_latency", W'(lat), W'(SW));
         check("tbl_b", b_s, tv[i].b);
`ifdef SHIFTER_STATUS_EN
         check("tbl_carry", W'(c_s), W'(tv[i].c));
         check("tbl_zero", W'(z_s), W'(tv[i].b == '0));
`endif
      end
      drain();

      // Six back-to-back rotates must come out on six consecutive cycles.
      first_v = -1;
      last_v  = -1;
      nv      = 0;
      for (int i = 0; i < 16; i++) begin
         in_valid = (i < 6);
         if (i < 6) begin
            a    = vals[i];
            sel  = 5'd5;
            mode = 3'd3;
         end
         tick();
         if (ov_s) begin
            if (first_v < 0) first_v = i;
            last_v = i;
            nv++;
            got.push_back(b_s);
         end
      end
      check("b2b_count", W'(nv), W'(6));
      check("b2b_span", W'(last_v - first_v + 1), W'(6));
      for (int i = 0; i < 6 && i < got.size(); i++)
         check("b2b_order", got[i], exp6[i]);
      drain();

      // Fill the pipe with the consumer stalled, then stall three more.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a    = $urandom;
      sel  = SW'($urandom);
      mode = 3'($urandom);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (acc_s) begin
            a    = $urandom;
            sel  = SW'($urandom);
            mode = 3'($urandom);
         end
      end
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_inflight", W'(sb.size()), W'(SW));
      repeat (3) tick();
      check("bp_still_full", W'(sb.size()), W'(SW));
      drain();

      // Randomized traffic; operands held while not accepted.
      in_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || acc_s) begin
            in_valid = 1'($urandom);
            a        = $urandom;
            sel      = SW'($urandom);
            mode     = 3'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      // Reset with operations in flight during a stall.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a    = $urandom;
         sel  = SW'($urandom);
         mode = 3'($urandom);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check("midrst_valid", W'(out_valid), W'(0));
      check("midrst_b", b, '0);
      sb.delete();
      hold_prev = 1'b0;
      @(posedge clock);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      repeat (8) tick();
      one_op(32'h0000001F, 5, 3, lat);
      check("postrst_latency", W'(lat), W'(SW));
      check("postrst_b", b_s, 32'h000003E0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
